branch_cond_unit: RTL and testbench

- Consumer side of the Low/Negative/Zero flag interface: reads the flag register outputs and resolves conditional branches/jumps for the control unit.
- Accepts one branch request at a time (condition code, PC, displacement), holds it while a flag update is in flight, evaluates the condition, and returns taken/target through a valid/ready response.
- Sits between the flag register and the PC-update logic.

---
 rtl/branch_cond_unit_pkg.sv | 32 +++
 rtl/branch_cond_unit_cond_eval.sv | 40 ++++
 rtl/branch_cond_unit.sv | 138 +++++++++++++
 tb/tb_branch_cond_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/branch_cond_unit_pkg.sv
// Shared definitions for the branch condition unit and the Low/Negative/Zero flag register.
// Holds condition-code constants, FSM state encoding and the flag bundle type.
package branch_cond_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_VS = 4'b1000;
  localparam logic [3:0] COND_VC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] ST_IDLE       = 2'b00;
  localparam logic [1:0] ST_WAIT_FLAGS = 2'b01;
  localparam logic [1:0] ST_RESP       = 2'b10;

  typedef struct packed {
    logic low;
    logic negative;
    logic zero;
  } flags_t;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Combinational condition evaluator: maps a condition code and flag bundle to taken/illegal.
// Carry/overflow codes are not backed by this flag set and are reported as illegal.
module cond_eval
  import branch_cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       taken,
  output logic       illegal
);

  // Decode the condition against the current flag bundle
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (cond)
      COND_EQ: taken = flags.zero;
      COND_NE: taken = ~flags.zero;
      COND_HI: taken = flags.low;
      COND_LS: taken = ~flags.low;
      COND_GT: taken = flags.negative;
      COND_LE: taken = ~flags.negative;
      COND_LO: taken = ~flags.low & ~flags.zero;
      COND_HS: taken = flags.low | flags.zero;
      COND_LT: taken = ~flags.negative & ~flags.zero;
      COND_GE: taken = flags.negative | flags.zero;
      COND_UC: taken = 1'b1;
      COND_NV: taken = 1'b0;
      COND_CS, COND_CC, COND_VS, COND_VC: begin
        taken   = 1'b0;
        illegal = 1'b1;
      end
      default: begin
        taken   = 1'b0;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds one branch request across in-flight flag updates,
// resolves it against the Low/Negative/Zero flags and returns taken/target via valid/ready.
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DISP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Low,
  input  logic              Negative,
  input  logic              Zero,
  input  logic              flag_enable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cond,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic [DISP_W-1:0] req_disp,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_taken,
  output logic [ADDR_W-1:0] resp_target,
  output logic              resp_illegal
);

  logic [1:0]        state_r;
  logic [3:0]        cond_r;
  logic [ADDR_W-1:0] pc_r;
  logic [DISP_W-1:0] disp_r;
  logic              req_ready_r;
  logic              resp_valid_r;
  logic              resp_taken_r;
  logic              resp_illegal_r;
  logic [ADDR_W-1:0] resp_target_r;

  flags_t            flags_s;
  logic [3:0]        eval_cond_s;
  logic [ADDR_W-1:0] eval_pc_s;
  logic [DISP_W-1:0] eval_disp_s;
  logic              taken_s;
  logic              illegal_s;
  logic [ADDR_W-1:0] target_s;

  assign flags_s = '{low: Low, negative: Negative, zero: Zero};

  // In IDLE the request is evaluated straight from the ports; later from the captured copy
  always_comb begin
    if (state_r == ST_IDLE) begin
      eval_cond_s = req_cond;
      eval_pc_s   = req_pc;
      eval_disp_s = req_disp;
    end else begin
      eval_cond_s = cond_r;
      eval_pc_s   = pc_r;
      eval_disp_s = disp_r;
    end
  end

  cond_eval u_cond_eval (
    .cond    (eval_cond_s),
    .flags   (flags_s),
    .taken   (taken_s),
    .illegal (illegal_s)
  );

  // Branch target, wrapping silently modulo 2^ADDR_W
  always_comb begin
    if (taken_s) begin
      target_s = eval_pc_s + {{(ADDR_W-DISP_W){eval_disp_s[DISP_W-1]}}, eval_disp_s};
    end else begin
      target_s = eval_pc_s + ADDR_W'(1);
    end
  end

  // Request/response FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      cond_r         <= 4'b0000;
      pc_r           <= '0;
      disp_r         <= '0;
      req_ready_r    <= 1'b1;
      resp_valid_r   <= 1'b0;
      resp_taken_r   <= 1'b0;
      resp_illegal_r <= 1'b0;
      resp_target_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            cond_r      <= req_cond;
            pc_r        <= req_pc;
            disp_r      <= req_disp;
            req_ready_r <= 1'b0;
            if (flag_enable) begin
              state_r <= ST_WAIT_FLAGS;
            end else begin
              state_r        <= ST_RESP;
              resp_valid_r   <= 1'b1;
              resp_taken_r   <= taken_s;
              resp_illegal_r <= illegal_s;
              resp_target_r  <= target_s;
            end
          end
        end
        ST_WAIT_FLAGS: begin
          if (!flag_enable) begin
            state_r        <= ST_RESP;
            resp_valid_r   <= 1'b1;
            resp_taken_r   <= taken_s;
            resp_illegal_r <= illegal_s;
            resp_target_r  <= target_s;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_r      <= ST_IDLE;
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
          req_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_r;
  assign resp_valid   = resp_valid_r;
  assign resp_taken   = resp_taken_r;
  assign resp_illegal = resp_illegal_r;
  assign resp_target  = resp_target_r;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed vector table, hand-written
// hazard/backpressure/reset sequences and an exhaustive code x flag sweep.
module tb_branch_cond_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Low, Negative, Zero, flag_enable;
  logic        req_valid, req_ready;
  logic [3:0]  req_cond;
  logic [15:0] req_pc;
  logic [7:0]  req_disp;
  logic        resp_valid, resp_ready, resp_taken, resp_illegal;
  logic [15:0] resp_target;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  branch_cond_unit #(.ADDR_W(16), .DISP_W(8)) dut (
    .clk(clk), .reset(reset), .Low(Low), .Negative(Negative), .Zero(Zero),
    .flag_enable(flag_enable), .req_valid(req_valid), .req_ready(req_ready),
    .req_cond(req_cond), .req_pc(req_pc), .req_disp(req_disp),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_taken(resp_taken),
    .resp_target(resp_target), .resp_illegal(resp_illegal)
  );

  typedef struct {
    logic [3:0]  cond;
    logic [2:0]  lnz;
    logic [15:0] pc;
    logic [7:0]  disp;
    logic        taken;
    logic        illegal;
    logic [15:0] target;
  } vec_t;

  // taken mask per code, bit index = {L,N,Z}
  logic [7:0]  taken_mask [16];
  logic [15:0] illegal_codes;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [2:0] lnz);
    Low = lnz[2]; Negative = lnz[1]; Zero = lnz[0];
  endtask

  // Issue one request with flag_enable=0, check latency-1 response, then handshake
  task automatic run_txn(input string name, input logic [3:0] c, input logic [2:0] lnz,
                         input logic [15:0] pc, input logic [7:0] d,
                         input logic et, input logic ei, input logic [15:0] etgt);
    set_flags(lnz);
    req_cond = c; req_pc = pc; req_disp = d; req_valid = 1'b1; flag_enable = 1'b0;
    step();
    req_valid = 1'b0;
    check({name, " valid"}, 16'(resp_valid), 16'd1);
    check({name, " taken"}, 16'(resp_taken), 16'(et));
    check({name, " illegal"}, 16'(resp_illegal), 16'(ei));
    check({name, " target"}, resp_target, etgt);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({name, " idle"}, 16'(resp_valid), 16'd0);
  endtask

  vec_t vecs [8];

  initial begin
    logic [15:0] held_tgt;
    logic        held_tk;

    taken_mask = '{8'hAA, 8'h55, 8'h00, 8'h00, 8'hF0, 8'h0F, 8'hCC, 8'h33,
                   8'h00, 8'h00, 8'h05, 8'hFA, 8'h11, 8'hEE, 8'hFF, 8'h00};
    illegal_codes = 16'h030C;

    vecs[0] = '{4'b0000, 3'b001, 16'h0010, 8'hFE, 1'b1, 1'b0, 16'h000E};
    vecs[1] = '{4'b0000, 3'b000, 16'h0010, 8'hFE, 1'b0, 1'b0, 16'h0011};
    vecs[2] = '{4'b0010, 3'b111, 16'h1234, 8'h05, 1'b0, 1'b1, 16'h1235};
    vecs[3] = '{4'b1111, 3'b111, 16'h1234, 8'h05, 1'b0, 1'b0, 16'h1235};
    vecs[4] = '{4'b1110, 3'b000, 16'hFFFF, 8'h01, 1'b1, 1'b0, 16'h0000};
    vecs[5] = '{4'b0100, 3'b100, 16'h8000, 8'h80, 1'b1, 1'b0, 16'h7F80};
    vecs[6] = '{4'b1100, 3'b010, 16'hFFFF, 8'h80, 1'b0, 1'b0, 16'h0000};
    vecs[7] = '{4'b1001, 3'b000, 16'h0200, 8'h10, 1'b0, 1'b1, 16'h0201};

    reset = 1'b0; flag_enable = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_cond = 4'b0000; req_pc = 16'h0000; req_disp = 8'h00; set_flags(3'b000);
    step(); step();
    check("rst req_ready", 16'(req_ready), 16'd1);
    check("rst resp_valid", 16'(resp_valid), 16'd0);
    check("rst taken", 16'(resp_taken), 16'd0);
    check("rst target", resp_target, 16'h0000);
    check("rst illegal", 16'(resp_illegal), 16'd0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].cond, vecs[i].lnz, vecs[i].pc, vecs[i].disp,
              vecs[i].taken, vecs[i].illegal, vecs[i].target);

    // Hazard: LT held while flag_enable=1 for 3 cycles, flags N 1->0
    set_flags(3'b010);
    req_cond = 4'b1100; req_pc = 16'h0040; req_disp = 8'h08; req_valid = 1'b1; flag_enable = 1'b1;
    step();
    req_valid = 1'b0; req_cond = 4'b0000;
    set_flags(3'b000);
    check("haz ready0", 16'(req_ready), 16'd0);
    step();
    check("haz wait1", 16'(resp_valid), 16'd0);
    step();
    check("haz wait2", 16'(resp_valid), 16'd0);
    flag_enable = 1'b0;
    step();
    check("haz valid", 16'(resp_valid), 16'd1);
    check("haz taken", 16'(resp_taken), 16'd1);
    check("haz target", resp_target, 16'h0048);

    // Backpressure: hold 5 cycles with toggling flags and a stray request
    held_tgt = 16'h0048; held_tk = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_flags(3'(k * 3 + 1));
      req_valid = 1'b1; req_cond = 4'b1111; flag_enable = k[0];
      step();
      check("bp valid", 16'(resp_valid), 16'd1);
      check("bp taken", 16'(resp_taken), 16'(held_tk));
      check("bp target", resp_target, held_tgt);
      check("bp ready", 16'(req_ready), 16'd0);
    end
    req_valid = 1'b0; flag_enable = 1'b0; resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp release valid", 16'(resp_valid), 16'd0);
    check("bp release ready", 16'(req_ready), 16'd1);

    // Reset in WAIT_FLAGS aborts without a response
    req_cond = 4'b1110; req_pc = 16'h0100; req_disp = 8'h20; req_valid = 1'b1; flag_enable = 1'b1;
    step();
    req_valid = 1'b0;
    check("abort wait ready", 16'(req_ready), 16'd0);
    #2 reset = 1'b0;
    #1;
    check("abort valid", 16'(resp_valid), 16'd0);
    check("abort ready", 16'(req_ready), 16'd1);
    check("abort target", resp_target, 16'h0000);
    step();
    reset = 1'b1; flag_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort no resp", 16'(resp_valid), 16'd0);
    end

    // Exhaustive code x flag sweep against mask model
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic [15:0] pc;
        logic [7:0]  d;
        logic        et;
        logic        ei;
        logic [15:0] tgt;
        pc = 16'(16'h1000 + c * 37 + f);
        d  = 8'(c * 19 + f * 41);
        et = taken_mask[c][f];
        ei = illegal_codes[c];
        tgt = et ? 16'(pc + {{8{d[7]}}, d}) : 16'(pc + 16'd1);
        run_txn($sformatf("ex c%0d f%0d", c, f), 4'(c), 3'(f), pc, d, et, ei, tgt);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
